// File: rtl/quad_readout_arbiter_pkg.sv
// Shared constants for the quadrant readout path (readout FSMs, arbiter, host unpacker).
package quad_readout_arbiter_pkg;

  localparam int PIX_WORD_W  = 16;
  localparam int N_QUAD      = 4;
  localparam int QUAD_ID_W   = 2;
  localparam int FRAME_WORDS = 1024;
  localparam int WC_W        = 12;
  localparam int FRAME_CNT_W = 16;

  typedef logic [PIX_WORD_W-1:0] pix_word_t;

  // Round-robin index helper: (base + off) wrapped into [0, n).
  function automatic int rr_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/quad_readout_arbiter_if.sv
// Source-side and host-FIFO-side signals of the quadrant readout arbiter.
interface quad_readout_arbiter_if #(
  parameter int N_SRC = quad_readout_arbiter_pkg::N_QUAD,
  parameter int ID_W  = quad_readout_arbiter_pkg::QUAD_ID_W
);
  import quad_readout_arbiter_pkg::*;

  logic [N_SRC-1:0]            src_wr;
  logic [PIX_WORD_W*N_SRC-1:0] src_data;
  logic                        fifo_full;
  logic                        ovf_clr;
  logic                        fifo_wr;
  pix_word_t                   fifo_din;
  logic [ID_W-1:0]             fifo_src;
  logic [N_SRC-1:0]            ovf;
  logic                        frame_done;
  logic [FRAME_CNT_W-1:0]      frame_cnt;

  modport master (
    output src_wr, src_data, fifo_full, ovf_clr,
    input  fifo_wr, fifo_din, fifo_src, ovf, frame_done, frame_cnt
  );

  modport slave (
    input  src_wr, src_data, fifo_full, ovf_clr,
    output fifo_wr, fifo_din, fifo_src, ovf, frame_done, frame_cnt
  );

endinterface

// File: rtl/quad_readout_arbiter_src_word_fifo.sv
// Small per-source word buffer; pointers carry an extra wrap bit so full and empty differ.
module src_word_fifo import quad_readout_arbiter_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = PIX_WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  // A push into a full buffer is still taken when the head leaves in the same cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  // Read/write pointer advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until the write pointer passes them.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/quad_readout_arbiter.sv
// Merges four quadrant readout streams into the host FIFO with round-robin arbitration,
// sticky per-source overflow flags and a completed-frame counter.
module quad_readout_arbiter import quad_readout_arbiter_pkg::*; #(
  parameter int N_SRC       = N_QUAD,
  parameter int DEPTH       = 4,
  parameter int FRAME_WORDS = quad_readout_arbiter_pkg::FRAME_WORDS
) (
  input logic                   clk,
  input logic                   rst,
  quad_readout_arbiter_if.slave io_bus
);

  localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]       w_empty;
  logic [N_SRC-1:0]       w_full;
  logic [N_SRC-1:0]       w_pop;
  logic [N_SRC-1:0]       w_req;
  logic [N_SRC-1:0]       w_drop;
  pix_word_t              w_head [N_SRC];
  logic [ID_W-1:0]        w_base;
  logic [2*N_SRC-1:0]     w_req_dbl;
  logic [N_SRC-1:0]       w_req_rot;
  logic                   w_gnt_vld;
  logic [ID_W-1:0]        w_gnt_id;
  logic                   w_frame_all;

  logic [ID_W-1:0]        r_last;
  logic [WC_W-1:0]        r_wc [N_SRC];
  logic                   r_fifo_wr;
  pix_word_t              r_fifo_din;
  logic [ID_W-1:0]        r_fifo_src;
  logic [N_SRC-1:0]       r_ovf;
  logic                   r_frame_done;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    src_word_fifo #(.DEPTH(DEPTH), .WIDTH(PIX_WORD_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (io_bus.src_wr[g]),
      .i_pop   (w_pop[g]),
      .i_data  (io_bus.src_data[PIX_WORD_W*g +: PIX_WORD_W]),
      .o_data  (w_head[g]),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g])
    );
  end

  // The host full flag is sampled one cycle ahead of the write, hence the one-slot margin.
  assign w_req  = io_bus.fifo_full ? '0 : ~w_empty;
  assign w_drop = io_bus.src_wr & w_full & ~w_pop;

  // Rotate requests so last+1 sits at bit 0, pick the lowest set bit, rotate the index back.
  always_comb begin
    w_base    = ID_W'(rr_idx(int'(r_last), 1, N_SRC));
    w_req_dbl = {w_req, w_req} >> w_base;
    w_req_rot = w_req_dbl[N_SRC-1:0];
    w_gnt_vld = |w_req_rot;
    w_gnt_id  = '0;
    w_pop     = '0;
    for (int j = N_SRC - 1; j >= 0; j--) begin
      if (w_req_rot[j]) w_gnt_id = ID_W'(rr_idx(int'(w_base), j, N_SRC));
    end
    if (w_gnt_vld) w_pop[w_gnt_id] = 1'b1;
  end

  // A frame is complete once every source has forwarded at least FRAME_WORDS words.
  always_comb begin
    w_frame_all = 1'b1;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_wc[i] < WC_W'(FRAME_WORDS)) w_frame_all = 1'b0;
    end
  end

  // Host write port, priority pointer, overflow flags and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo_wr    <= 1'b0;
      r_fifo_din   <= '0;
      r_fifo_src   <= '0;
      r_last       <= ID_W'(N_SRC - 1);
      r_ovf        <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_fifo_wr <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_fifo_din <= w_head[w_gnt_id];
        r_fifo_src <= w_gnt_id;
        r_last     <= w_gnt_id;
      end
      r_ovf        <= (r_ovf & ~{N_SRC{io_bus.ovf_clr}}) | w_drop;
      r_frame_done <= w_frame_all;
      if (w_frame_all) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // Per-source word counters; surplus words carry into the next frame, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) r_wc[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (w_frame_all)
          r_wc[i] <= r_wc[i] - WC_W'(FRAME_WORDS) + WC_W'(w_pop[i]);
        else if (w_pop[i] && (r_wc[i] != {WC_W{1'b1}}))
          r_wc[i] <= r_wc[i] + 1'b1;
      end
    end
  end

  assign io_bus.fifo_wr    = r_fifo_wr;
  assign io_bus.fifo_din   = r_fifo_din;
  assign io_bus.fifo_src   = r_fifo_src;
  assign io_bus.ovf        = r_ovf;
  assign io_bus.frame_done = r_frame_done;
  assign io_bus.frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_quad_readout_arbiter.sv
// Scoreboard bench for quad_readout_arbiter: stimulus pushes expected words, a negedge monitor checks them.
module tb_quad_readout_arbiter;
  import quad_readout_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0]  src;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  quad_readout_arbiter_if bus ();

  quad_readout_arbiter #(.N_SRC(4), .DEPTH(4), .FRAME_WORDS(1024)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_fd     = 0;
  exp_t exp_q[$];
  logic [1:0] exp_src_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every host write must match the oldest pending word of its source.
  always @(negedge clk) begin
    int idx;
    if (!rst) begin
      if (bus.frame_done) n_fd++;
      if (bus.fifo_wr) begin
        idx = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
          if (exp_q[k].src == bus.fifo_src) begin
            idx = k;
            break;
          end
        end
        if (idx < 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got src %0d data %h, required no write (t=%0t)",
                   bus.fifo_src, bus.fifo_din, $time);
        end else begin
          check("word_data", 32'(bus.fifo_din), 32'(exp_q[idx].data));
          exp_q.delete(idx);
        end
        if (exp_src_q.size() > 0) begin
          check("rr_order", 32'(bus.fifo_src), 32'(exp_src_q[0]));
          void'(exp_src_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Present a one-cycle push on the sources in mask; data for source i sits in d[16i+15:16i].
  task automatic push(input logic [3:0] mask, input logic [63:0] d, input bit expect_out);
    exp_t e;
    bus.src_wr   = mask;
    bus.src_data = d;
    for (int i = 0; i < 4; i++) begin
      if (mask[i] && expect_out) begin
        e.src  = 2'(i);
        e.data = d[16*i +: 16];
        exp_q.push_back(e);
      end
    end
    tick();
    bus.src_wr = '0;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) tick();
    check({"drain_", nm}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_fifo_wr"},    32'(bus.fifo_wr),    32'd0);
    check({nm, "_fifo_din"},   32'(bus.fifo_din),   32'd0);
    check({nm, "_fifo_src"},   32'(bus.fifo_src),   32'd0);
    check({nm, "_ovf"},        32'(bus.ovf),        32'd0);
    check({nm, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    check({nm, "_frame_cnt"},  32'(bus.frame_cnt),  32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rem [4];
    int cnt [4];
    int s;
    int wr_seen;
    logic [63:0] d;

    bus.src_wr    = '0;
    bus.src_data  = '0;
    bus.fifo_full = 1'b0;
    bus.ovf_clr   = 1'b0;

    // Reset state
    at_neg();
    check_reset_vals("reset");
    tick();
    rst = 1'b0;
    tick();

    // Round robin from reset: src 0,1,2,3 on consecutive cycles
    exp_src_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    push(4'hF, 64'hA003_A002_A001_A000, 1'b1);
    at_neg();
    check("rr_latency_wr0", 32'(bus.fifo_wr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("rr_burst_wr", 32'(bus.fifo_wr), 32'd1);
    end
    at_neg();
    check("rr_burst_end", 32'(bus.fifo_wr), 32'd0);
    tick();
    // Repeat burst restarts at src 0 since last=3
    exp_src_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    push(4'hF, 64'hB003_B002_B001_B000, 1'b1);
    wait_drain("rr", 20);
    check("rr_src_q_empty", 32'(exp_src_q.size()), 32'd0);

    // Single source: word pushed at edge k appears after edge k+1, gone the cycle after
    push(4'b0100, 64'h0000_1234_0000_0000, 1'b1);
    at_neg();
    check("single_wr_early", 32'(bus.fifo_wr), 32'd0);
    at_neg();
    check("single_wr", 32'(bus.fifo_wr), 32'd1);
    check("single_din", 32'(bus.fifo_din), 32'h1234);
    check("single_src", 32'(bus.fifo_src), 32'd2);
    at_neg();
    check("single_wr_drop", 32'(bus.fifo_wr), 32'd0);
    tick();

    // Backpressure: src 1 fills its buffer, fifth word is dropped and flagged
    bus.fifo_full = 1'b1;
    tick();
    wr_seen = 0;
    for (int p = 0; p < 5; p++) begin
      d = 64'(16'hC000 + p) << 16;
      push(4'b0010, d, p < 4);
      at_neg();
      if (bus.fifo_wr) wr_seen++;
      if (p == 3) check("bp_ovf_before", 32'(bus.ovf), 32'd0);
      if (p == 4) check("bp_ovf_set", 32'(bus.ovf), 32'b0010);
      tick();
    end
    check("bp_no_write", 32'(wr_seen), 32'd0);
    bus.fifo_full = 1'b0;
    wait_drain("bp", 20);
    repeat (5) tick();

    // Simultaneous clear and overflow on src 3
    bus.fifo_full = 1'b1;
    for (int p = 0; p < 4; p++) push(4'b1000, 64'(16'hD000 + p) << 48, 1'b1);
    at_neg();
    check("clr_ovf_sticky", 32'(bus.ovf), 32'b0010);
    tick();
    bus.ovf_clr = 1'b1;
    push(4'b1000, 64'hDEAD_0000_0000_0000, 1'b0);
    bus.ovf_clr = 1'b0;
    at_neg();
    check("clr_and_set", 32'(bus.ovf), 32'b1000);
    tick();
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    at_neg();
    check("clr_alone", 32'(bus.ovf), 32'd0);
    tick();
    bus.fifo_full = 1'b0;
    wait_drain("clr", 20);
    repeat (5) tick();

    // Reset between tests so the frame counters start from zero
    rst = 1'b1;
    at_neg();
    check_reset_vals("rst2");
    tick();
    rst = 1'b0;
    tick();

    // Frame 1: staggered sources, src 0 sends 6 extra words
    rem = '{1030, 1024, 1024, 1024};
    cnt = '{0, 0, 0, 0};
    for (int c = 0; rem[0] + rem[1] + rem[2] + rem[3] > 0; c++) begin
      s = c % 4;
      if (rem[s] > 0) begin
        d = 64'({s[1:0], 14'(cnt[s])}) << (16 * s);
        push(4'(1 << s), d, 1'b1);
        rem[s]--;
        cnt[s]++;
      end else begin
        tick();
      end
    end
    wait_drain("frame1", 50);
    repeat (5) tick();
    at_neg();
    check("frame1_pulses", 32'(n_fd), 32'd1);
    check("frame1_cnt", 32'(bus.frame_cnt), 32'd1);
    check("frame1_ovf", 32'(bus.ovf), 32'd0);
    tick();

    // Frame 2: the 6 carried words of src 0 complete its share
    rem = '{1018, 1024, 1024, 1024};
    for (int c = 0; rem[0] + rem[1] + rem[2] + rem[3] > 0; c++) begin
      s = c % 4;
      if (rem[s] > 0) begin
        d = 64'({s[1:0], 14'(cnt[s])}) << (16 * s);
        push(4'(1 << s), d, 1'b1);
        rem[s]--;
        cnt[s]++;
      end else begin
        tick();
      end
    end
    wait_drain("frame2", 50);
    repeat (5) tick();
    at_neg();
    check("frame2_pulses", 32'(n_fd), 32'd2);
    check("frame2_cnt", 32'(bus.frame_cnt), 32'd2);
    tick();

    // Reset mid-burst: three words buffered, reset asserted between edges
    bus.fifo_full = 1'b1;
    push(4'b0111, 64'h0000_E002_E001_E000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    tick();
    tick();
    rst = 1'b0;
    bus.fifo_full = 1'b0;
    wr_seen = 0;
    for (int c = 0; c < 10; c++) begin
      at_neg();
      if (bus.fifo_wr) wr_seen++;
      tick();
    end
    check("rst_no_stale", 32'(wr_seen), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
